// File: rtl/gray_pkg.sv
// gray_pkg: shared constants for the grayscale pipe (coefficients, pixel fields, lanes)
package gray_pkg;
  localparam int COEF_R_DEF = 77;
  localparam int COEF_G_DEF = 150;
  localparam int COEF_B_DEF = 29;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam int LANES = 4;
  localparam int GRAY_W = 8;
endpackage

// File: rtl/gray_pixel_pipe_if.sv
// gray_pixel_pipe_if: pixel-in / packed-word-out stream handshake bundle
interface gray_pixel_pipe_if import gray_pkg::*; ;
  logic s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic m_valid, m_ready, m_last;
  logic [LANES*GRAY_W-1:0] m_data;
  logic [LANES-1:0] m_keep;
  modport master(output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data, m_keep, m_last);
  modport slave(input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data, m_keep, m_last);
endinterface

// File: rtl/gray_pixel_pipe_mac.sv
// gray_luma_mac: two-stage weighted-sum luma (products, then sum); GRAY_ROUND_EN rounds instead of truncating
module gray_luma_mac import gray_pkg::*; #(
  parameter int COEF_R = COEF_R_DEF,
  parameter int COEF_G = COEF_G_DEF,
  parameter int COEF_B = COEF_B_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [23:0]       pix,
  output logic              out_valid,
  output logic              out_last,
  output logic [GRAY_W-1:0] gray
);
`ifdef GRAY_ROUND_EN
  localparam logic [16:0] BIAS = 17'd128;
`else
  localparam logic [16:0] BIAS = 17'd0;
`endif
  logic [15:0] pr, pg, pb;
  logic v1, l1;
  logic [16:0] sum;
  // S1: register the three channel products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, l1, pr, pg, pb} <= '0;
    end else if (en) begin
      v1 <= in_valid;
      l1 <= in_last;
      pr <= 16'(pix[R_LSB+:8] * COEF_R);
      pg <= 16'(pix[G_LSB+:8] * COEF_G);
      pb <= 16'(pix[B_LSB+:8] * COEF_B);
    end
  end
  // S2 adder: weights sum to 256, so the integer part of sum/256 is the luma byte
  always_comb sum = 17'(pr) + 17'(pg) + 17'(pb) + BIAS;
  // S2: register the gray byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {out_valid, out_last, gray} <= '0;
    end else if (en) begin
      out_valid <= v1;
      out_last  <= l1;
      gray      <= GRAY_W'(sum >> 8);
    end
  end
endmodule

// File: rtl/gray_pixel_pipe.sv
// gray_pixel_pipe: RGB->gray stream, packs four gray bytes per word, counts accepted pixels; GRAY_ROUND_EN selects rounding
module gray_pixel_pipe import gray_pkg::*; #(
  parameter int COEF_R = COEF_R_DEF,
  parameter int COEF_G = COEF_G_DEF,
  parameter int COEF_B = COEF_B_DEF,
  parameter int CNT_W  = 32
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  gray_pixel_pipe_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] pix_count
);
  logic en, acc, g_valid, g_last, done;
  logic [GRAY_W-1:0] gray;
  logic [1:0] idx;
  logic [LANES*GRAY_W-1:0] pack, nd;
  logic [LANES-1:0] keep, nk;
  // whole pipe advances whenever the output register is empty or being drained
  always_comb begin
    en = !bus.m_valid || bus.m_ready;
    bus.s_ready = ARESETN && en;
    acc = bus.s_valid && bus.s_ready;
  end
  gray_luma_mac #(.COEF_R(COEF_R), .COEF_G(COEF_G), .COEF_B(COEF_B)) u_mac (
    .clk(ACLK), .rst_n(ARESETN), .en(en), .in_valid(acc), .in_last(bus.s_last),
    .pix(bus.s_data[23:0]), .out_valid(g_valid), .out_last(g_last), .gray(gray)
  );
  // next packed word with the incoming gray byte merged into its lane
  always_comb begin
    nd = pack | ((LANES*GRAY_W)'(gray) << {idx, 3'b000});
    nk = keep | (LANES'(1) << idx);
    done = g_valid && (idx == 2'd3 || g_last);
  end
  // packer accumulator: restarts at lane 0 after every emitted word
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      {idx, pack, keep} <= '0;
    end else if (en && g_valid) begin
      idx  <= done ? 2'd0 : idx + 2'd1;
      pack <= done ? '0 : nd;
      keep <= done ? '0 : nk;
    end
  end
  // output word register: reloads on completion, holds while stalled
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last} <= '0;
    end else if (en) begin
      bus.m_valid <= done;
      if (done) begin
        bus.m_data <= nd;
        bus.m_keep <= nk;
        bus.m_last <= g_last;
      end
    end
  end
  // accepted-pixel counter; a clear in the same cycle as an accept leaves 1
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) pix_count <= '0;
    else pix_count <= (cnt_clr ? '0 : pix_count) + CNT_W'(acc);
  end
endmodule

// File: tb/tb_gray_pixel_pipe.sv
// tb_gray_pixel_pipe: scoreboard bench with a behavioural luma/packing model
module tb_gray_pixel_pipe;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  logic ACLK = 0, ARESETN = 0, cnt_clr = 0;
  logic [31:0] pix_count;
  logic [3:0] small_count;
  int checks = 0, failures = 0, words = 0;
  word_t exp_q[$];
  logic [7:0] lanes[$];
  logic [31:0] exp_cnt = 0;
  word_t last_word;
  word_t prev;
  bit hold_prev = 0;
  bit done_rand = 0;
  gray_pixel_pipe_if bif();
  gray_pixel_pipe_if sif();
  assign sif.s_valid = bif.s_valid;
  assign sif.s_data = bif.s_data;
  assign sif.s_last = bif.s_last;
  assign sif.m_ready = bif.m_ready;
  gray_pixel_pipe dut (.ACLK(ACLK), .ARESETN(ARESETN), .bus(bif), .cnt_clr(cnt_clr), .pix_count(pix_count));
  gray_pixel_pipe #(.CNT_W(4)) dut_small (.ACLK(ACLK), .ARESETN(ARESETN), .bus(sif), .cnt_clr(cnt_clr), .pix_count(small_count));
  always #5 ACLK = ~ACLK;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] luma(input logic [31:0] p);
    int s;
    s = int'(p[23:16]) * 77 + int'(p[15:8]) * 150 + int'(p[7:0]) * 29;
`ifdef GRAY_ROUND_EN
    s += 128;
`endif
    return 8'(s / 256);
  endfunction

  task automatic model_pixel(input logic [31:0] p, input logic l);
    word_t w;
    lanes.push_back(luma(p));
    if (lanes.size() == 4 || l) begin
      w = '0;
      foreach (lanes[i]) begin
        w.d[8*i+:8] = lanes[i];
        w.k[i] = 1'b1;
      end
      w.l = l;
      exp_q.push_back(w);
      lanes.delete();
    end
  endtask

  always @(negedge ACLK) begin
    word_t cur, e;
    cur = '{bif.m_data, bif.m_keep, bif.m_last};
    if (!ARESETN) begin
      lanes.delete();
      exp_cnt = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", bif.m_valid, 1);
        chk("stall_word", cur, prev);
      end
      hold_prev = bif.m_valid && !bif.m_ready;
      prev = cur;
      if (bif.m_valid && bif.m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", cur, 0);
        else begin
          e = exp_q.pop_front();
          chk("word", cur, e);
        end
        last_word = cur;
        words++;
      end
      chk("pix_count", pix_count, exp_cnt);
      chk("small_count", small_count, exp_cnt[3:0]);
      if (bif.s_valid && bif.s_ready) begin
        model_pixel(bif.s_data, bif.s_last);
        exp_cnt = (cnt_clr ? 0 : exp_cnt) + 1;
      end else if (cnt_clr) exp_cnt = 0;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 0;
    bif.s_valid = 1;
    bif.s_data = d;
    bif.s_last = l;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge ACLK);
      ok = bif.s_ready;
      @(posedge ACLK);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    bif.s_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic drain;
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge ACLK);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    bif.s_valid = 0; bif.s_data = 0; bif.s_last = 0; bif.m_ready = 1;
    repeat (2) @(negedge ACLK);
    chk("rst_s_ready", bif.s_ready, 0);
    chk("rst_m_valid", bif.m_valid, 0);
    chk("rst_m_data", bif.m_data, 0);
    chk("rst_m_keep", bif.m_keep, 0);
    chk("rst_m_last", bif.m_last, 0);
    chk("rst_pix_count", pix_count, 0);
    @(posedge ACLK); #1 ARESETN = 1;
    @(negedge ACLK);
    chk("ready_after_rst", bif.s_ready, 1);
    @(posedge ACLK); #1;
    send(32'h00FFFFFF, 0); send(32'h00000000, 0); send(32'h00FF0000, 0); send(32'h0000FF00, 0);
    @(negedge ACLK); chk("lat_edge1", bif.m_valid, 0);
    @(negedge ACLK); chk("lat_edge2", bif.m_valid, 0);
    @(negedge ACLK); chk("lat_edge3", bif.m_valid, 1);
    #1;
`ifdef GRAY_ROUND_EN
    chk("t1_data", last_word.d, 32'h954D00FF);
`else
    chk("t1_data", last_word.d, 32'h954C00FF);
`endif
    chk("t1_keep", last_word.k, 4'hF);
    chk("t1_last", last_word.l, 0);
    chk("t1_count", pix_count, 4);
    @(posedge ACLK); #1;
    send(32'h000000FF, 1);
    idle(5);
`ifdef GRAY_ROUND_EN
    chk("t2_data", last_word.d, 32'h0000001D);
`else
    chk("t2_data", last_word.d, 32'h0000001C);
`endif
    chk("t2_keep", last_word.k, 4'h1);
    chk("t2_last", last_word.l, 1);
    w0 = words;
    fork
      for (int i = 0; i < 8; i++) send($urandom, 0);
      begin
        for (int t = 0; t < 100 && !bif.m_valid; t++) @(negedge ACLK);
        @(posedge ACLK); #1 bif.m_ready = 0;
        repeat (6) @(negedge ACLK);
        chk("stall_s_ready", bif.s_ready, 0);
        chk("stall_m_valid", bif.m_valid, 1);
        @(posedge ACLK); #1 bif.m_ready = 1;
      end
    join
    drain();
    chk("t3_words", words - w0, 2);
    send(32'h00123456, 0); send(32'h00ABCDEF, 0);
    ARESETN = 0;
    @(negedge ACLK); chk("midrst_s_ready", bif.s_ready, 0);
    @(posedge ACLK); #1 ARESETN = 1;
    w0 = words;
    repeat (4) send(32'h00FFFFFF, 0);
    idle(6);
    chk("t4_words", words - w0, 1);
    chk("t4_data", last_word.d, 32'hFFFFFFFF);
    chk("t4_count", pix_count, 4);
    cnt_clr = 1; idle(1); cnt_clr = 0;
    @(negedge ACLK); chk("clr_alone", pix_count, 0);
    @(posedge ACLK); #1;
    repeat (16) send($urandom, 0);
    @(negedge ACLK);
    chk("wrap_small", small_count, 0);
    chk("count16", pix_count, 16);
    @(posedge ACLK); #1;
    cnt_clr = 1; send($urandom, 0); cnt_clr = 0;
    @(negedge ACLK); chk("clr_with_accept", pix_count, 1);
    @(posedge ACLK); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom, $urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done_rand = 1;
      end
      while (!done_rand) begin
        @(posedge ACLK); #1 bif.m_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bif.m_ready = 1;
    send($urandom, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
